// File: rtl/bg_dma_loader_if.sv
// Bus bundle for bg_dma_loader: game-state control, SRAM read port, OCM write port and status.
// The master modport is the loader's view; slave is the surrounding system's view.
interface bg_dma_loader_if #(
  parameter int unsigned DW      = 16,
  parameter int unsigned SRAM_AW = 20,
  parameter int unsigned OCM_AW  = 19,
  parameter int unsigned SEL_W   = 2
);
  // Control
  logic               start;
  logic               abort;
  logic [SEL_W-1:0]   bg_sel;
  logic               fill_mode;
  logic [DW-1:0]      fill_word;
  // SRAM read port
  logic               sram_req;
  logic [SRAM_AW-1:0] sram_addr;
  logic [DW-1:0]      sram_rdata;
  logic               sram_ack;
  // OCM write port
  logic               ocm_we;
  logic [OCM_AW-1:0]  ocm_addr;
  logic [DW-1:0]      ocm_wdata;
  logic               ocm_ack;
  // Status
  logic               busy;
  logic               done;
  logic               aborted;
  logic               mark_hit;
  logic [SRAM_AW-1:0] words_done;

  modport master (
    input  start, abort, bg_sel, fill_mode, fill_word, sram_rdata, sram_ack, ocm_ack,
    output sram_req, sram_addr, ocm_we, ocm_addr, ocm_wdata,
    output busy, done, aborted, mark_hit, words_done
  );

  modport slave (
    output start, abort, bg_sel, fill_mode, fill_word, sram_rdata, sram_ack, ocm_ack,
    input  sram_req, sram_addr, ocm_we, ocm_addr, ocm_wdata,
    input  busy, done, aborted, mark_hit, words_done
  );
endinterface

// File: rtl/bg_dma_loader.sv
// Background loader: copies one stored background from SRAM into the OCM frame buffer,
// or fills it with a constant word. Supports abort and an optional end-marker stop.
module bg_dma_loader #(
  parameter int unsigned   DW       = 16,
  parameter int unsigned   SRAM_AW  = 20,
  parameter int unsigned   OCM_AW   = 19,
  parameter int unsigned   NUM_BG   = 4,
  parameter int unsigned   BG_WORDS = 153600,
  parameter bit            MARK_EN  = 1'b1,
  parameter logic [DW-1:0] MARK_MIN = DW'(16'hF000)
) (
  input logic             Clk,
  input logic             Reset_n,
  bg_dma_loader_if.master bus
);

  localparam logic [SRAM_AW-1:0] LastIdx = SRAM_AW'(BG_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StFin} state_e;

  state_e             state_q, state_d;
  logic               sram_req_q, ocm_we_q;
  logic [SRAM_AW-1:0] base_q, base_d;
  logic [SRAM_AW-1:0] idx_q;
  logic [DW-1:0]      skid_q;
  logic [DW-1:0]      fill_word_q;
  logic               fill_q;
  logic               mark_hit_q;
  logic               done_q;
  logic               aborted_q;

  logic start_ok;
  logic abort_hit;
  logic rd_ack;
  logic wr_ack;
  logic is_mark;

  always_comb begin
    start_ok  = (state_q == StIdle) && bus.start;
    abort_hit = (state_q != StIdle) && bus.abort;
    // An ack arriving together with abort is dropped.
    rd_ack    = (state_q == StRead) && bus.sram_ack && !bus.abort;
    wr_ack    = (state_q == StWrite) && bus.ocm_ack && !bus.abort;
    is_mark   = MARK_EN && (bus.sram_rdata >= MARK_MIN);
    if (32'(bus.bg_sel) >= NUM_BG) begin
      base_d = '0;
    end else begin
      base_d = SRAM_AW'(bus.bg_sel) * SRAM_AW'(BG_WORDS);
    end
  end

  // State register; request strobes are registered from the next state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      sram_req_q <= 1'b0;
      ocm_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sram_req_q <= (state_d == StRead);
      ocm_we_q   <= (state_d == StWrite);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = bus.fill_mode ? StWrite : StRead;
        end
      end
      StRead: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (bus.sram_ack) begin
          state_d = is_mark ? StFin : StWrite;
        end
      end
      StWrite: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (bus.ocm_ack) begin
          if (idx_q == LastIdx) begin
            state_d = StFin;
          end else begin
            state_d = fill_q ? StWrite : StRead;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Datapath: latched request parameters, skid word, word index and status pulses.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      base_q      <= '0;
      idx_q       <= '0;
      skid_q      <= '0;
      fill_word_q <= '0;
      fill_q      <= 1'b0;
      mark_hit_q  <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      done_q    <= (state_q == StFin) && !bus.abort;
      aborted_q <= abort_hit;
      if (start_ok) begin
        base_q      <= base_d;
        idx_q       <= '0;
        mark_hit_q  <= 1'b0;
        fill_q      <= bus.fill_mode;
        fill_word_q <= bus.fill_word;
      end
      if (rd_ack) begin
        skid_q <= bus.sram_rdata;
        if (is_mark) begin
          mark_hit_q <= 1'b1;
        end
      end
      if (wr_ack) begin
        idx_q <= idx_q + SRAM_AW'(1);
      end
    end
  end

  // idx only advances on accepted writes, so it doubles as the written-word count.
  always_comb begin
    bus.sram_req   = sram_req_q;
    bus.sram_addr  = base_q + idx_q;
    bus.ocm_we     = ocm_we_q;
    bus.ocm_addr   = OCM_AW'({idx_q, 1'b0});
    bus.ocm_wdata  = fill_q ? fill_word_q : skid_q;
    bus.busy       = (state_q != StIdle);
    bus.done       = done_q;
    bus.aborted    = aborted_q;
    bus.mark_hit   = mark_hit_q;
    bus.words_done = idx_q;
  end

endmodule

// File: tb/tb_bg_dma_loader.sv
// Scoreboard bench for bg_dma_loader: a queue-based reference model predicts SRAM reads,
// OCM writes and completion status; a negedge monitor pops and compares.
module tb_bg_dma_loader;
  localparam int unsigned DW        = 16;
  localparam int unsigned SRAM_AW   = 20;
  localparam int unsigned OCM_AW    = 19;
  localparam int unsigned NUM_BG    = 4;
  localparam int unsigned BG_WORDS  = 8;
  localparam int unsigned MEM_WORDS = NUM_BG * BG_WORDS;
  localparam logic [DW-1:0] MARK_MIN = 16'hF000;

  typedef struct packed {
    logic               aborted;
    logic               mark;
    logic [SRAM_AW-1:0] words;
  } end_t;

  logic clk;
  logic rst_n;

  bg_dma_loader_if #(.DW(DW), .SRAM_AW(SRAM_AW), .OCM_AW(OCM_AW), .SEL_W(2)) bus ();

  bg_dma_loader #(
    .DW(DW), .SRAM_AW(SRAM_AW), .OCM_AW(OCM_AW), .NUM_BG(NUM_BG), .BG_WORDS(BG_WORDS),
    .MARK_EN(1'b1), .MARK_MIN(MARK_MIN)
  ) dut (
    .Clk(clk),
    .Reset_n(rst_n),
    .bus(bus)
  );

  logic [DW-1:0]           mem [MEM_WORDS];
  logic [SRAM_AW-1:0]      exp_sram_q [$];
  logic [OCM_AW+DW-1:0]    exp_ocm_q [$];
  end_t                    exp_end_q [$];

  int total = 0;
  int bad = 0;
  int ends_seen = 0;
  int sram_dly = 0;
  int ocm_dly = 0;
  int abort_at = -1;
  int wr_cnt = 0;
  logic abort_main = 1'b0;
  logic abort_rsp = 1'b0;

  assign bus.abort = abort_main | abort_rsp;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctl"}, {bus.sram_req, bus.ocm_we, bus.busy, bus.done, bus.aborted,
                          bus.mark_hit}, 0);
    check({tag, "_words"}, bus.words_done, 0);
    check({tag, "_addr"}, {bus.sram_addr, bus.ocm_addr}, 0);
    check({tag, "_wdata"}, bus.ocm_wdata, 0);
  endtask

  // Reference: walk the background word by word, stopping at a marker or the abort point.
  task automatic model(input int sel, input bit fill, input logic [DW-1:0] fw, input int ab_at);
    int base;
    int n;
    bit mark;
    bit ab;
    logic [DW-1:0] w;
    base = (sel < int'(NUM_BG)) ? sel * int'(BG_WORDS) : 0;
    n = 0;
    mark = 1'b0;
    ab = 1'b0;
    for (int i = 0; i < int'(BG_WORDS); i++) begin
      w = fw;
      if (!fill) begin
        w = mem[base + i];
        exp_sram_q.push_back(SRAM_AW'(base + i));
        if (w >= MARK_MIN) begin
          mark = 1'b1;
          break;
        end
      end
      if (i == ab_at) begin
        ab = 1'b1;
        break;
      end
      exp_ocm_q.push_back({OCM_AW'(2 * i), w});
      n++;
    end
    exp_end_q.push_back('{aborted: ab, mark: mark, words: SRAM_AW'(n)});
  endtask

  // SRAM slave: ack after sram_dly idle cycles, one-cycle ack per request.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.sram_ack = 1'b0;
    bus.sram_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.sram_ack || !bus.sram_req || !rst_n) begin
        bus.sram_ack = 1'b0;
        wait_cnt = 0;
      end else if (wait_cnt >= sram_dly) begin
        bus.sram_ack = 1'b1;
        bus.sram_rdata = mem[bus.sram_addr[4:0]];
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // OCM slave: ack after ocm_dly idle cycles; raises abort together with the ack of write abort_at.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    bus.ocm_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.ocm_ack || abort_rsp || !bus.ocm_we || !rst_n) begin
        bus.ocm_ack = 1'b0;
        abort_rsp = 1'b0;
        wait_cnt = 0;
      end else if (wait_cnt >= ocm_dly) begin
        bus.ocm_ack = 1'b1;
        wait_cnt = 0;
        if (wr_cnt == abort_at) abort_rsp = 1'b1;
        else wr_cnt++;
      end else begin
        wait_cnt++;
      end
    end
  end

  // Monitor
  initial begin
    logic s_pend;
    logic o_pend;
    logic ab_prev;
    logic [SRAM_AW-1:0] s_addr;
    logic [OCM_AW+DW-1:0] o_ad;
    end_t e;
    s_pend = 1'b0;
    o_pend = 1'b0;
    ab_prev = 1'b0;
    s_addr = '0;
    o_ad = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        s_pend = 1'b0;
        o_pend = 1'b0;
        ab_prev = 1'b0;
        continue;
      end
      if (ab_prev) check("abort_to_idle", {bus.busy, bus.aborted, bus.done}, 3'b010);
      ab_prev = bus.abort && bus.busy;
      if (bus.sram_req && s_pend) check("sram_addr_stable", bus.sram_addr, s_addr);
      if (bus.ocm_we && o_pend) check("ocm_stable", {bus.ocm_addr, bus.ocm_wdata}, o_ad);
      s_pend = bus.sram_req && !bus.sram_ack;
      s_addr = bus.sram_addr;
      o_pend = bus.ocm_we && !bus.ocm_ack;
      o_ad = {bus.ocm_addr, bus.ocm_wdata};
      if (bus.sram_req && bus.sram_ack && !bus.abort) begin
        if (exp_sram_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sram_unexpected: got read of %0h expected none", bus.sram_addr);
        end else begin
          check("sram_addr", bus.sram_addr, exp_sram_q.pop_front());
        end
      end
      if (bus.ocm_we && bus.ocm_ack && !bus.abort) begin
        if (exp_ocm_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ocm_unexpected: got write %0h/%0h expected none",
                   bus.ocm_addr, bus.ocm_wdata);
        end else begin
          check("ocm_write", {bus.ocm_addr, bus.ocm_wdata}, exp_ocm_q.pop_front());
        end
      end
      if (bus.done || bus.aborted) begin
        ends_seen++;
        if (exp_end_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL end_unexpected: got done=%0b aborted=%0b expected none",
                   bus.done, bus.aborted);
        end else begin
          e = exp_end_q.pop_front();
          check("end_kind", {bus.done, bus.aborted}, {~e.aborted, e.aborted});
          check("words_done", bus.words_done, e.words);
          check("mark_hit", bus.mark_hit, e.mark);
        end
      end
    end
  end

  task automatic run_load(input int sel, input bit fill, input logic [DW-1:0] fw, input int ab_at,
                          input int sd, input int od, input bit ab_with_start, input bit restart);
    int target;
    int budget;
    sram_dly = sd;
    ocm_dly = od;
    abort_at = ab_at;
    wr_cnt = 0;
    model(sel, fill, fw, ab_at);
    target = ends_seen + 1;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.bg_sel = 2'(sel);
    bus.fill_mode = fill;
    bus.fill_word = fw;
    abort_main = ab_with_start;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    abort_main = 1'b0;
    // Scramble the request inputs; the load must use the values latched at start.
    bus.bg_sel = 2'($urandom);
    bus.fill_mode = 1'($urandom);
    bus.fill_word = 16'($urandom);
    if (restart && bus.busy) begin
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    budget = 0;
    while (ends_seen < target && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    total++;
    if (ends_seen < target) begin
      bad++;
      $display("FAIL load_timeout: got %0d completions expected %0d", ends_seen, target);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.bg_sel = '0;
    bus.fill_mode = 1'b0;
    bus.fill_word = '0;
    for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = 16'(i % 8 + 1);
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Plain copy of background 2, then marker at word 3 of background 1, then fill.
    run_load(2, 1'b0, '0, -1, 0, 0, 1'b0, 1'b0);
    mem[11] = 16'hF000;
    run_load(1, 1'b0, '0, -1, 0, 0, 1'b0, 1'b0);
    run_load(3, 1'b1, 16'h00AA, -1, 0, 0, 1'b0, 1'b0);

    // Abort while the 4th write is pending (with its ack), then a clean reload.
    run_load(0, 1'b0, '0, 3, 0, 0, 1'b0, 1'b0);
    run_load(0, 1'b0, '0, -1, 0, 0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a read.
    sram_dly = 8;
    abort_at = -1;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.bg_sel = 2'd0;
    bus.fill_mode = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("read_before_reset", {bus.busy, bus.sram_req}, 2'b11);
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    check("start_in_reset", {bus.busy, bus.sram_req, bus.ocm_we}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Slow slaves with a start while busy, start+abort together, abort while idle.
    run_load(2, 1'b0, '0, -1, 5, 3, 1'b0, 1'b1);
    run_load(2, 1'b0, '0, -1, 0, 1, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    abort_main = 1'b1;
    @(posedge clk);
    #1;
    abort_main = 1'b0;
    @(negedge clk);
    check("idle_abort", {bus.busy, bus.aborted, bus.done}, 0);

    // Marker on the very first word.
    mem[24] = 16'hF123;
    run_load(3, 1'b0, '0, -1, 0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = 16'($urandom);
      run_load(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 16'($urandom),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 7) == 0), 1'($urandom));
    end

    check("sram_q_empty", exp_sram_q.size(), 0);
    check("ocm_q_empty", exp_ocm_q.size(), 0);
    check("end_q_empty", exp_end_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
